// File: rtl/point_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : point_link_pkg
// Description : Shared types, width helpers and header layout for the
//               multi-channel point-to-point link.
// Revision    : 1.0 - initial release
// ============================================================================
package point_link_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2
   } tx_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_PAY  = 1'b1
   } rx_state_t;

   // Header beat carries the channel number in its low bits; the rest is zero.
   localparam int HDR_CHAN_LSB = 0;

   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/point_master_link_if.sv
`default_nettype none
// ============================================================================
// Module      : point_master_link_if
// Description : Channel-side TX/RX and lane-side signals of the link master.
// Revision    : 1.0 - initial release
// ============================================================================
interface point_master_link_if #(
   parameter int CHANNELS = 4,
   parameter int WORD_W   = 32,
   parameter int LANE_W   = 8,
   parameter int CH_W     = point_link_pkg::width_of(CHANNELS)
);
   logic [CHANNELS-1:0]        tx_valid;
   logic [CHANNELS-1:0]        tx_ready;
   logic [CHANNELS*WORD_W-1:0] tx_data;
   logic [LANE_W-1:0]          lane_o;
   logic                       lane_o_vld;
   logic                       lane_o_sof;
   logic                       lane_rdy;
   logic [LANE_W-1:0]          lane_i;
   logic                       lane_i_vld;
   logic                       lane_i_sof;
   logic                       rx_valid;
   logic [CH_W-1:0]            rx_chan;
   logic [WORD_W-1:0]          rx_data;
   logic                       rx_err;

   modport master (
      input  tx_valid, tx_data, lane_rdy, lane_i, lane_i_vld, lane_i_sof,
      output tx_ready, lane_o, lane_o_vld, lane_o_sof, rx_valid, rx_chan, rx_data, rx_err
   );

   modport slave (
      output tx_valid, tx_data, lane_rdy, lane_i, lane_i_vld, lane_i_sof,
      input  tx_ready, lane_o, lane_o_vld, lane_o_sof, rx_valid, rx_chan, rx_data, rx_err
   );
endinterface
`default_nettype wire

// File: rtl/point_link_fifo.sv
`default_nettype none
// ============================================================================
// Module      : point_link_fifo
// Description : Per-channel synchronous TX FIFO with registered ready and a
//               look-ahead "non-empty next cycle" flag for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module point_link_fifo
   import point_link_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             ready,
   output logic             avail
);
   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q, ready_d;
   logic             push_ok, pop_ok;

   // Ready reflects the occupancy before this cycle's pop, so a full FIFO
   // refuses a push even while it is being drained.
   always_comb begin
      push_ok = push & ready_q;
      pop_ok  = pop & (count_q != '0);
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop_ok);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      ready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

   assign dout  = mem_q[rd_q];
   assign ready = ready_q;
   assign avail = (count_d != '0);

endmodule
`default_nettype wire

// File: rtl/point_master_link.sv
`default_nettype none
// ============================================================================
// Module      : point_master_link
// Description : Multiplexes CHANNELS word streams onto one framed LANE_W lane
//               (round-robin) and deframes the incoming lane into words.
// Revision    : 1.0 - initial release
// ============================================================================
module point_master_link
   import point_link_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 4,
   parameter int WORD_W   = 32,
   parameter int LANE_W   = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   point_master_link_if.master  link
);
   localparam int CH_W   = width_of(CHANNELS);
   localparam int BEATS  = WORD_W / LANE_W;
   localparam int BEAT_W = width_of(BEATS);

   logic [WORD_W-1:0]   head [CHANNELS];
   logic [CHANNELS-1:0] avail, pop, tx_ready_w;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
      point_link_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
         .clock (clock),
         .reset (reset),
         .push  (link.tx_valid[c]),
         .pop   (pop[c]),
         .din   (link.tx_data[c*WORD_W +: WORD_W]),
         .dout  (head[c]),
         .ready (tx_ready_w[c]),
         .avail (avail[c])
      );
   end
   assign link.tx_ready = tx_ready_w;

   tx_state_t         tx_state_q, tx_state_d;
   logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d, next_rr, base, pick;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [LANE_W-1:0] lane_q, lane_d, hdr;
   logic              vld_q, vld_d, sof_q, sof_d, last_beat, any_avail;
   logic [WORD_W-1:0] head_g;

   assign head_g = head[grant_q];

   always_comb begin
      last_beat = (tx_state_q == PAY) && link.lane_rdy && (beat_q == BEAT_W'(BEATS-1));
      pop       = '0;
      if (last_beat) pop[grant_q] = 1'b1;
      next_rr   = (grant_q == CH_W'(CHANNELS-1)) ? '0 : grant_q + CH_W'(1);
   end

   // Arbitrate on next-cycle occupancy: includes this cycle's pushes (for the
   // one-cycle header latency) and this cycle's pop (for back-to-back frames).
   always_comb begin
      int idx;
      base      = last_beat ? next_rr : rr_q;
      pick      = '0;
      any_avail = 1'b0;
      for (int i = CHANNELS-1; i >= 0; i--) begin
         idx = int'(base) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (avail[CH_W'(idx)]) begin
            pick      = CH_W'(idx);
            any_avail = 1'b1;
         end
      end
      hdr = '0;
      hdr[HDR_CHAN_LSB +: CH_W] = pick;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      beat_d     = beat_q;
      lane_d     = lane_q;
      vld_d      = vld_q;
      sof_d      = sof_q;
      case (tx_state_q)
         IDLE: begin
            if (any_avail) begin
               tx_state_d = HDR;
               grant_d    = pick;
               lane_d     = hdr;
               vld_d      = 1'b1;
               sof_d      = 1'b1;
            end
         end
         HDR: begin
            if (link.lane_rdy) begin
               tx_state_d = PAY;
               beat_d     = '0;
               lane_d     = head_g[0 +: LANE_W];
               sof_d      = 1'b0;
            end
         end
         PAY: begin
            if (last_beat) begin
               rr_d = next_rr;
               if (any_avail) begin
                  tx_state_d = HDR;
                  grant_d    = pick;
                  lane_d     = hdr;
                  sof_d      = 1'b1;
               end else begin
                  tx_state_d = IDLE;
                  lane_d     = '0;
                  vld_d      = 1'b0;
                  sof_d      = 1'b0;
               end
            end else if (link.lane_rdy) begin
               beat_d = beat_q + BEAT_W'(1);
               lane_d = head_g[int'(beat_d)*LANE_W +: LANE_W];
            end
         end
         default: tx_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= IDLE;
         grant_q    <= '0;
         rr_q       <= '0;
         beat_q     <= '0;
         lane_q     <= '0;
         vld_q      <= 1'b0;
         sof_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         beat_q     <= beat_d;
         lane_q     <= lane_d;
         vld_q      <= vld_d;
         sof_q      <= sof_d;
      end
   end

   assign link.lane_o     = lane_q;
   assign link.lane_o_vld = vld_q;
   assign link.lane_o_sof = sof_q;

   rx_state_t         rx_state_q, rx_state_d;
   logic [CH_W-1:0]   cur_q, cur_d, rx_chan_q, rx_chan_d;
   logic [BEAT_W-1:0] rbeat_q, rbeat_d;
   logic [WORD_W-1:0] acc_q, acc_d, rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;

   always_comb begin
      rx_state_d = rx_state_q;
      cur_d      = cur_q;
      rbeat_d    = rbeat_q;
      acc_d      = acc_q;
      rx_chan_d  = rx_chan_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      if (link.lane_i_vld) begin
         if (link.lane_i_sof) begin
            if (rx_state_q == R_PAY) rx_err_d = 1'b1;
            // Whole header is compared so stray upper bits also count as a bad channel.
            if (link.lane_i > LANE_W'(CHANNELS-1)) begin
               rx_err_d   = 1'b1;
               rx_state_d = R_IDLE;
            end else begin
               rx_state_d = R_PAY;
               cur_d      = link.lane_i[CH_W-1:0];
               rbeat_d    = '0;
            end
         end else if (rx_state_q == R_IDLE) begin
            rx_err_d = 1'b1;
         end else begin
            acc_d[int'(rbeat_q)*LANE_W +: LANE_W] = link.lane_i;
            if (rbeat_q == BEAT_W'(BEATS-1)) begin
               rx_valid_d = 1'b1;
               rx_chan_d  = cur_q;
               rx_data_d  = acc_d;
               rx_state_d = R_IDLE;
            end else begin
               rbeat_d = rbeat_q + BEAT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state_q <= R_IDLE;
         cur_q      <= '0;
         rbeat_q    <= '0;
         acc_q      <= '0;
         rx_chan_q  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         cur_q      <= cur_d;
         rbeat_q    <= rbeat_d;
         acc_q      <= acc_d;
         rx_chan_q  <= rx_chan_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign link.rx_valid = rx_valid_q;
   assign link.rx_chan  = rx_chan_q;
   assign link.rx_data  = rx_data_q;
   assign link.rx_err   = rx_err_q;

endmodule
`default_nettype wire
